// File: rtl/unidade_de_busca_pkg.sv
// Shared definitions for the fetch/step sequencer and the control logic that decodes it.
package unidade_de_busca_pkg;

    localparam int unsigned WORD_WIDTH_DEF = 9;
    localparam int unsigned OPCODE_WIDTH   = 3;
    localparam int unsigned STEP_WIDTH     = 2;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD    = 3'b000;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB    = 3'b001;
    localparam logic [OPCODE_WIDTH-1:0] OP_NAN    = 3'b010;
    localparam logic [OPCODE_WIDTH-1:0] OP_ILL_A  = 3'b011;
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT    = 3'b100;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI    = 3'b101;
    localparam logic [OPCODE_WIDTH-1:0] OP_ILL_B  = 3'b110;
    localparam logic [OPCODE_WIDTH-1:0] OP_REP    = 3'b111;

    localparam logic [STEP_WIDTH-1:0] STEP0 = 2'b00;
    localparam logic [STEP_WIDTH-1:0] STEP1 = 2'b01;
    localparam logic [STEP_WIDTH-1:0] STEP2 = 2'b10;
    localparam logic [STEP_WIDTH-1:0] STEP3 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_FETCH     = 2'b01,
        S_FETCH_IMM = 2'b10,
        S_STEP      = 2'b11
    } state_t;

    function automatic logic opcode_is_legal(input logic [OPCODE_WIDTH-1:0] op);
        return (op != OP_ILL_A) && (op != OP_ILL_B);
    endfunction

endpackage

// File: rtl/unidade_de_busca_fila_de_instrucoes.sv
// Synchronous FIFO buffering instruction/immediate words; head word is read combinationally.
module fila_de_instrucoes #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch and step sequencer: buffers words, holds iin/imm, and drives the step counter.
module unidade_de_busca
    import unidade_de_busca_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [STEP_WIDTH-1:0] counter,
    output logic [WORD_WIDTH-1:0] iin,
    output logic [WORD_WIDTH-1:0] imm,
    output logic                  done,
    output logic                  busy,
    output logic                  illegal
);

    state_t                  state;
    logic [WORD_WIDTH-1:0]   head;
    logic [OPCODE_WIDTH-1:0] head_op;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop_c;

    assign head_op  = head[WORD_WIDTH-1 -: OPCODE_WIDTH];
    assign in_ready = !fifo_full;

    fila_de_instrucoes #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fila (
        .clock   (clock),
        .reset   (reset),
        .push    (in_valid),
        .pop     (pop_c),
        .wr_data (in_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Words leave the FIFO only in FETCH (run high) or FETCH_IMM.
    always_comb begin
        pop_c = 1'b0;
        case (state)
            S_FETCH:     pop_c = run && !fifo_empty;
            S_FETCH_IMM: pop_c = !fifo_empty;
            default:     pop_c = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            counter <= STEP0;
            iin     <= '0;
            imm     <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    counter <= STEP0;
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    counter <= STEP0;
                    if (!run) begin
                        state <= S_IDLE;
                    end else if (!fifo_empty) begin
                        if (!opcode_is_legal(head_op)) begin
                            illegal <= 1'b1;
                        end else begin
                            iin  <= head;
                            busy <= 1'b1;
                            state <= (head_op == OP_LDI) ? S_FETCH_IMM : S_STEP;
                        end
                    end
                end
                S_FETCH_IMM: begin
                    if (!fifo_empty) begin
                        imm   <= head;
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    // The done cycle doubles as the next FETCH cycle.
                    if (counter == STEP3) begin
                        counter <= STEP0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_FETCH;
                    end else begin
                        counter <= counter + STEP_WIDTH'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
